apb3_requester_arb: RTL and testbench
=====================================

Name: apb3_requester_arb

Overview:
- Round-robin arbiter and APB3 sequencer that lets N independent requesters share one APB3 completer, typically a generated register block.
- Each requester issues single read/write commands over a valid/ready handshake.
- The block grants one requester, runs the APB3 SETUP/ACCESS protocol, and returns read data and error status to the granted requester.
- Sits between CPU-side/DMA-side agents and the register-block `s_apb` port.

Parameters:
- N_REQ, 2: number of requesters (2..8).
- ADDR_W, 12: APB address width.
- TIMEOUT_CYCLES, 64: ACCESS-phase watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester command valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_write  in  N_REQ  1=write, 0=read.
- req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*32  packed write data.
- rsp_valid  out  N_REQ  one-cycle completion pulse, one-hot.
- rsp_rdata  out  32  read data, valid with rsp_valid; shared by all requesters.
- rsp_err  out  1  PSLVERR (or timeout) status, valid with rsp_valid.
- m_apb_psel  out  1  APB select.
- m_apb_penable  out  1  APB enable.
- m_apb_pwrite  out  1  APB write.
- m_apb_paddr  out  ADDR_W  APB address.
- m_apb_pwdata  out  32  APB write data.
- m_apb_prdata  in  32  APB read data.
- m_apb_pready  in  1  APB ready.
- m_apb_pslverr  in  1  APB error.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; psel, penable, pwrite=0; paddr, pwdata=0.
  - rsp_valid=0; rsp_rdata=0; rsp_err=0.
  - Round-robin pointer = N_REQ-1, so requester 0 wins first.
  - Reset mid-transfer drops psel/penable immediately and discards the transfer; no rsp_valid is produced for it.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready is combinational. If any req_valid is high, select the first requester g with req_valid set, searching from pointer+1 modulo N_REQ. Assert req_ready[g] in the same cycle.
  - On that edge: latch write/addr/wdata of g into the APB output registers; pointer<=g; state<=SETUP.
  - Requesters hold valid and payload stable until ready. Dropping valid before ready is legal (no transfer occurs).
- SETUP: psel=1, penable=0, for exactly one cycle; then ACCESS.
- ACCESS:
  - psel=1, penable=1. Wait states are unbounded while pready=0.
  - Cycle with pready=1: next edge drives rsp_valid[g]=1, rsp_rdata=prdata (writes capture prdata too, value don't-care), rsp_err=pslverr. psel/penable<=0; state<=IDLE.
- Latency:
  - Accept-to-rsp_valid is 3 cycles with zero wait states.
  - Arbitration for the next command happens in the same cycle rsp_valid is high, so back-to-back transfers take 3 cycles each.
- APB outputs stay stable from SETUP through the completing ACCESS cycle; paddr/pwdata hold their last value in IDLE.
- req_ready is never asserted outside IDLE. rsp_valid is a single-cycle pulse.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0. A lone requester is granted every transfer.
- Simultaneous events: rsp_valid to requester A and req_ready to requester B in the same cycle is legal. A may re-request in that same cycle; it then loses to other valid requesters per the rotation.

Optional Feature:
- Macro: APB3_REQUESTER_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES, the next edge aborts: psel/penable<=0, rsp_valid[g]=1, rsp_err=1, rsp_rdata=32'hDEAD_BEEF, state<=IDLE.
  - A real pready on the same cycle as the limit takes priority.
- Undefined: no counter is present; ACCESS waits indefinitely.

Decomposition:
- Package apb3_requester_arb_pkg:
  - state enum (IDLE, SETUP, ACCESS).
  - TIMEOUT_RDATA constant 32'hDEAD_BEEF.
  - APB data width constant 32.
- Sub-module rr_arbiter: purely combinational pick taking valid vector + pointer and returning a one-hot grant and a grant index. Reusable elsewhere.

Test Plan:
- Single read: requester 0 reads 0x000, completer returns 0x1234_5678 with pready=1 first ACCESS cycle → psel rises 1 cycle after accept, penable 1 cycle later, rsp_valid[0] 3 cycles after accept, rsp_rdata=0x1234_5678, rsp_err=0.
- Write then read: requester 1 writes 0x100←0x0000_0000, then reads 0x100 → pwrite=1 with pwdata=0 in SETUP/ACCESS; the read returns the completer value; APB signals stable during 3 inserted wait states.
- Contention: both requesters hold valid (r0 reads 0x000, r1 writes 0x000←0xFFFF_FFFF) → r0 is granted first after reset, r1 next; rsp_valid order is r0 then r1; strict alternation over 8 transfers.
- Error: completer asserts pslverr=1 with pready on a read of 0x100 → rsp_err=1 with rsp_valid; FSM returns to IDLE and the next transfer is clean.
- Reset mid-ACCESS: assert rst low during wait states → psel/penable low immediately without a clock edge; no rsp_valid; after release, requester 0 is granted first.
- Timeout (macro defined, TIMEOUT_CYCLES=4): pready held low → rsp_valid with rsp_err=1 and rsp_rdata=0xDEAD_BEEF after 4 ACCESS cycles; with the macro undefined, no response until pready.

Source files
------------

// File: rtl/apb3_requester_arb_pkg.sv
// Shared types and constants for the APB3 requester arbiter.
// Optional ACCESS watchdog is enabled by APB3_REQUESTER_ARB_TIMEOUT_EN.
package apb3_requester_arb_pkg;

    localparam int APB_DATA_W = 32;

    localparam logic [APB_DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Bits above the round-robin pointer get first pick; wrap to the rest otherwise.
    function automatic logic [7:0] rr_upper_mask(input int n, input int ptr);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < n && i > ptr) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/apb3_requester_arb_rr_arbiter.sv
// Purely combinational round-robin pick: search starts one past ptr and wraps.
// Latency: zero cycles. Backpressure: none, the caller decides when a grant is consumed.
// Returns a one-hot grant, its index, and whether any request is present.
module rr_arbiter
    import apb3_requester_arb_pkg::*;
#(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [7:0]   upper_mask;
    logic [N-1:0] upper;

    always_comb begin
        upper_mask = rr_upper_mask(N, int'(ptr));
        upper      = valid & upper_mask[N-1:0];
        grant      = '0;
        grant_idx  = '0;
        // Lowest set bit wins; the upper-window pass overrides the wrapped pass.
        for (int i = N - 1; i >= 0; i--) begin
            if (valid[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (upper[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
        any = |valid;
    end

endmodule

// File: rtl/apb3_requester_arb.sv
// Round-robin APB3 sequencer sharing one completer among N_REQ requesters.
// Latency: accept-to-rsp_valid 3 cycles plus completer wait states; back-to-back every 3 cycles.
// Backpressure: req_ready only in IDLE; ACCESS stalls on pready (bounded when APB3_REQUESTER_ARB_TIMEOUT_EN).
module apb3_requester_arb
    import apb3_requester_arb_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0]             req_write,
    input  logic [N_REQ*ADDR_W-1:0]      req_addr,
    input  logic [N_REQ*APB_DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic [APB_DATA_W-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic                         m_apb_psel,
    output logic                         m_apb_penable,
    output logic                         m_apb_pwrite,
    output logic [ADDR_W-1:0]            m_apb_paddr,
    output logic [APB_DATA_W-1:0]        m_apb_pwdata,
    input  logic [APB_DATA_W-1:0]        m_apb_prdata,
    input  logic                         m_apb_pready,
    input  logic                         m_apb_pslverr
);

    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("apb3_requester_arb: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     ptr;
    logic [N_REQ-1:0]     grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_any;
    logic                 accept;
    logic                 finish;
    logic                 abort;
    logic                 to_hit;
    logic                 sel_write;
    logic [ADDR_W-1:0]    sel_addr;
    logic [APB_DATA_W-1:0] sel_wdata;
    logic [N_REQ-1:0]     ptr_onehot;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .valid     (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign req_ready = (state == IDLE) ? grant : '0;

    // Payload mux driven by the one-hot grant.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*APB_DATA_W +: APB_DATA_W];
            end
        end
    end

    // ptr always holds the requester that owns the current transfer.
    always_comb begin
        ptr_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ptr_onehot[i] = (ptr == IDX_W'(i));
        end
    end

`ifdef APB3_REQUESTER_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= '0;
        end else if (state == ACCESS && !m_apb_pready && !to_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A real pready outranks the watchdog in the same cycle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (m_apb_pready) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else if (to_hit) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr           <= IDX_W'(N_REQ - 1);
            m_apb_psel    <= 1'b0;
            m_apb_penable <= 1'b0;
            m_apb_pwrite  <= 1'b0;
            m_apb_paddr   <= '0;
            m_apb_pwdata  <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (accept) begin
                ptr          <= grant_idx;
                m_apb_psel   <= 1'b1;
                m_apb_pwrite <= sel_write;
                m_apb_paddr  <= sel_addr;
                m_apb_pwdata <= sel_wdata;
            end
            if (state == SETUP) begin
                m_apb_penable <= 1'b1;
            end
            if (finish || abort) begin
                m_apb_psel    <= 1'b0;
                m_apb_penable <= 1'b0;
                rsp_valid     <= ptr_onehot;
                rsp_rdata     <= finish ? m_apb_prdata : TIMEOUT_RDATA;
                rsp_err       <= finish ? m_apb_pslverr : 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb3_requester_arb.sv
// Self-checking bench for apb3_requester_arb: directed scenarios plus a randomized
// run against a transaction-level model (rotation rule, timeline, completer memory).
module tb_apb3_requester_arb;

    localparam int N  = 3;
    localparam int AW = 12;
    localparam int TO = 4;
    localparam logic [AW-1:0] ERR_ADDR = 12'h03C;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic            m_apb_psel;
    logic            m_apb_penable;
    logic            m_apb_pwrite;
    logic [AW-1:0]   m_apb_paddr;
    logic [31:0]     m_apb_pwdata;
    logic [31:0]     m_apb_prdata;
    logic            m_apb_pready;
    logic            m_apb_pslverr;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state
    int          last;
    bit          busy;
    bit          resp_due;
    int          cur;
    int          since;
    int          wcnt;
    bit          cw;
    logic [11:0] ca;
    logic [31:0] cd;
    bit          exp_wr;
    bit          exp_err;
    logic [31:0] exp_rdata;
    bit          pend [N];
    bit          pw   [N];
    logic [11:0] pa   [N];
    logic [31:0] pd   [N];
    logic [31:0] mem  [16];
    int          obs_grant [$];
    int          obs_rsp   [$];

    always #5 clk = ~clk;

    apb3_requester_arb #(
        .N_REQ          (N),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .m_apb_psel    (m_apb_psel),
        .m_apb_penable (m_apb_penable),
        .m_apb_pwrite  (m_apb_pwrite),
        .m_apb_paddr   (m_apb_paddr),
        .m_apb_pwdata  (m_apb_pwdata),
        .m_apb_prdata  (m_apb_prdata),
        .m_apb_pready  (m_apb_pready),
        .m_apb_pslverr (m_apb_pslverr)
    );

    task automatic model_reset();
        last     = N - 1;
        busy     = 0;
        resp_due = 0;
        for (int i = 0; i < N; i++) pend[i] = 0;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = pend[i];
            req_write[i]            = pw[i];
            req_addr[i*AW +: AW]    = pa[i];
            req_wdata[i*32 +: 32]   = pd[i];
        end
    endtask

    // Single requester transfer with `waits` pready-low ACCESS cycles.
    task automatic run_xfer(input int r, input bit w, input logic [11:0] a, input logic [31:0] wd,
                            input int waits, input logic [31:0] rd, input bit se);
        logic [N-1:0] onehot;
        onehot = N'(1 << r);
        @(posedge clk); #1;
        req_valid            = onehot;
        req_write[r]         = w;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*32 +: 32] = wd;
        m_apb_pready         = 1'b0;
        #1;
        checks++;
        if (req_ready !== onehot) begin
            errors++; $display("FAIL xfer_ready: got %b want %b", req_ready, onehot);
        end
        @(posedge clk); #1;
        req_valid = '0;
        checks++;
        if ({m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr, m_apb_pwdata} !== {1'b1, 1'b0, w, a, wd}) begin
            errors++; $display("FAIL xfer_setup: got sel=%b en=%b wr=%b addr=%h wd=%h want 1 0 %b %h %h",
                m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr, m_apb_pwdata, w, a, wd);
        end
        m_apb_prdata  = rd;
        m_apb_pslverr = se;
        for (int k = 0; k <= waits; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr, m_apb_pwdata, rsp_valid} !==
                {1'b1, 1'b1, w, a, wd, N'(0)}) begin
                errors++; $display("FAIL xfer_access[%0d]: got sel=%b en=%b wr=%b addr=%h wd=%h rsp=%b",
                    k, m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr, m_apb_pwdata, rsp_valid);
            end
            m_apb_pready = (k == waits);
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_err, m_apb_psel, m_apb_penable} !== {onehot, se, 1'b0, 1'b0} ||
            (!w && rsp_rdata !== rd)) begin
            errors++; $display("FAIL xfer_rsp: got rsp=%b err=%b rdata=%h sel=%b en=%b want %b %b %h 0 0",
                rsp_valid, rsp_err, rsp_rdata, m_apb_psel, m_apb_penable, onehot, se, rd);
        end
        m_apb_pready  = 1'b0;
        m_apb_pslverr = 1'b0;
        last = r;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== '0) begin
            errors++; $display("FAIL xfer_pulse: got %b want 0", rsp_valid);
        end
    endtask

    // Cycle-stepped randomized run; mode 1 = r0/r1 permanently contending with pready=1.
    task automatic run_engine(input int cycles, input int mode);
        int           g;
        int           p;
        bit           any_pend;
        logic [N-1:0] exp_ready;
        for (int c = 0; c < cycles + 400; c++) begin
            any_pend = 0;
            for (int i = 0; i < N; i++) if (pend[i]) any_pend = 1;
            if (c >= cycles && !busy && !resp_due && !any_pend) break;
            @(posedge clk); #1;
            if (busy) since++;
            for (int i = 0; i < N; i++) if (rsp_valid[i]) obs_rsp.push_back(i);
            checks++;
            if (resp_due) begin
                if (rsp_valid !== N'(1 << cur) || rsp_err !== exp_err || (!exp_wr && rsp_rdata !== exp_rdata)) begin
                    errors++; $display("FAIL eng_rsp: got rsp=%b err=%b rdata=%h want %b %b %h",
                        rsp_valid, rsp_err, rsp_rdata, N'(1 << cur), exp_err, exp_rdata);
                end
                busy = 0; resp_due = 0;
            end else if (rsp_valid !== '0) begin
                errors++; $display("FAIL eng_rsp_idle: got %b want 0", rsp_valid);
            end
            checks++;
            if (busy) begin
                if ({m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr, m_apb_pwdata} !==
                    {1'b1, (since >= 2), cw, ca, cd}) begin
                    errors++; $display("FAIL eng_apb: got sel=%b en=%b wr=%b addr=%h wd=%h want 1 %b %b %h %h",
                        m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr, m_apb_pwdata, (since >= 2), cw, ca, cd);
                end
            end else if ({m_apb_psel, m_apb_penable} !== 2'b00) begin
                errors++; $display("FAIL eng_apb_idle: got sel=%b en=%b want 0 0", m_apb_psel, m_apb_penable);
            end
            if (c < cycles) begin
                for (int i = 0; i < N; i++) begin
                    if (!pend[i]) begin
                        if (mode == 1) begin
                            if (i < 2) begin
                                pend[i] = 1; pw[i] = (i == 1); pa[i] = 12'h000;
                                pd[i] = (i == 1) ? 32'hFFFF_FFFF : 32'h0;
                            end
                        end else if ($urandom_range(0, 2) == 0) begin
                            pend[i] = 1; pw[i] = 1'($urandom_range(0, 1));
                            pa[i] = 12'($urandom_range(0, 15) * 4); pd[i] = $urandom;
                        end
                    end
                end
            end
            drive_reqs();
            if (busy && since >= 2) begin
                m_apb_pready  = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
                m_apb_prdata  = cw ? $urandom : mem[ca[5:2]];
                m_apb_pslverr = (ca == ERR_ADDR);
            end else begin
                m_apb_pready  = 1'($urandom_range(0, 1));
                m_apb_prdata  = $urandom;
                m_apb_pslverr = 1'($urandom_range(0, 1));
            end
            #1;
            g = -1;
            if (!busy) begin
                for (int k = 1; k <= N; k++) begin
                    p = (last + k) % N;
                    if (g < 0 && pend[p]) g = p;
                end
            end
            exp_ready = (g >= 0) ? N'(1 << g) : '0;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++; $display("FAIL eng_ready: got %b want %b", req_ready, exp_ready);
            end
            for (int i = 0; i < N; i++) if (req_ready[i]) obs_grant.push_back(i);
            if (g >= 0) begin
                busy = 1; cur = g; cw = pw[g]; ca = pa[g]; cd = pd[g];
                pend[g] = 0; since = 0; wcnt = 0; last = g;
            end else if (busy && since >= 2) begin
                if (m_apb_pready) begin
                    resp_due = 1; exp_wr = cw; exp_err = m_apb_pslverr; exp_rdata = m_apb_prdata;
                    if (cw) mem[ca[5:2]] = cd;
                end
`ifdef APB3_REQUESTER_ARB_TIMEOUT_EN
                else if (wcnt == TO) begin
                    resp_due = 1; exp_wr = 0; exp_err = 1; exp_rdata = 32'hDEAD_BEEF;
                end else begin
                    wcnt++;
                end
`endif
            end
        end
        checks++;
        if (busy || resp_due || req_valid !== '0) begin
            errors++; $display("FAIL eng_drain: busy=%b resp_due=%b valid=%b want all 0", busy, resp_due, req_valid);
        end
        m_apb_pready  = 1'b0;
        m_apb_pslverr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        m_apb_pready = 1'b0; m_apb_prdata = '0; m_apb_pslverr = 1'b0;
        #3;
        checks++;
        if ({m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr, m_apb_pwdata, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
            errors++; $display("FAIL reset_outputs: sel=%b en=%b wr=%b addr=%h wd=%h rsp=%b rdata=%h err=%b want all 0",
                m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr, m_apb_pwdata, rsp_valid, rsp_rdata, rsp_err);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
    endtask

    task automatic test_contention();
        obs_grant.delete();
        obs_rsp.delete();
        run_engine(24, 1);
        checks++;
        if (obs_grant.size() < 8 || obs_rsp.size() < 8) begin
            errors++; $display("FAIL contention_count: grants=%0d rsps=%0d want >=8", obs_grant.size(), obs_rsp.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (obs_grant[k] != k % 2 || obs_rsp[k] != k % 2) begin
                    errors++; $display("FAIL contention_order[%0d]: grant=%0d rsp=%0d want %0d", k, obs_grant[k], obs_rsp[k], k % 2);
                end
            end
        end
    endtask

    task automatic test_single_read();
        run_xfer(0, 1'b0, 12'h000, 32'h0, 0, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_write_read();
        run_xfer(1, 1'b1, 12'h100, 32'h0000_0000, 3, 32'h0BAD_0BAD, 1'b0);
        run_xfer(1, 1'b0, 12'h100, 32'h0000_0000, 3, 32'hA5A5_0F0F, 1'b0);
    endtask

    task automatic test_error();
        run_xfer(0, 1'b0, 12'h100, 32'h0, 1, 32'h7777_1111, 1'b1);
        run_xfer(1, 1'b0, 12'h004, 32'h0, 0, 32'h0000_55AA, 1'b0);
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        req_valid = 3'b010; req_write[1] = 1'b0; req_addr[AW +: AW] = 12'h020;
        m_apb_pready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 3'b010) begin
            errors++; $display("FAIL rstmid_ready: got %b want 010", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({m_apb_psel, m_apb_penable, rsp_valid} !== '0) begin
            errors++; $display("FAIL rstmid_async: sel=%b en=%b rsp=%b want 0", m_apb_psel, m_apb_penable, rsp_valid);
        end
        m_apb_pready = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1;
        model_reset();
        m_apb_pready = 1'b0;
        req_valid = 3'b011;
        req_write[0] = 1'b0; req_addr[0 +: AW] = 12'h000;
        req_write[1] = 1'b1; req_addr[AW +: AW] = 12'h000;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++; $display("FAIL rstmid_first_grant: got %b want 001", req_ready);
        end
        #1 req_valid = '0;
        @(posedge clk); #1;
        checks++;
        if ({m_apb_psel, m_apb_penable, rsp_valid} !== '0) begin
            errors++; $display("FAIL rstmid_no_rsp: sel=%b en=%b rsp=%b want 0", m_apb_psel, m_apb_penable, rsp_valid);
        end
    endtask

    task automatic test_timeout();
        int bad;
        int hold;
        bad = 0;
        @(posedge clk); #1;
        req_valid = 3'b001; req_write[0] = 1'b0; req_addr[0 +: AW] = 12'h008;
        m_apb_pready = 1'b0; m_apb_prdata = 32'h0BAD_F00D; m_apb_pslverr = 1'b0;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++; $display("FAIL timeout_ready: got %b want 001", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
`ifdef APB3_REQUESTER_ARB_TIMEOUT_EN
        hold = TO + 1;
`else
        hold = 20;
`endif
        for (int s = 0; s < hold; s++) begin
            @(posedge clk); #1;
            if (rsp_valid !== '0 || m_apb_psel !== 1'b1 || m_apb_penable !== 1'b1) bad++;
`ifndef APB3_REQUESTER_ARB_TIMEOUT_EN
            if (s == hold - 1) m_apb_pready = 1'b1;
`endif
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL timeout_hold: %0d bad cycles want 0", bad);
        end
        @(posedge clk); #1;
        checks++;
`ifdef APB3_REQUESTER_ARB_TIMEOUT_EN
        if ({rsp_valid, rsp_err, rsp_rdata, m_apb_psel} !== {3'b001, 1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            errors++; $display("FAIL timeout_abort: rsp=%b err=%b rdata=%h sel=%b want 001 1 deadbeef 0",
                rsp_valid, rsp_err, rsp_rdata, m_apb_psel);
        end
`else
        if ({rsp_valid, rsp_err, rsp_rdata, m_apb_psel} !== {3'b001, 1'b0, 32'h0BAD_F00D, 1'b0}) begin
            errors++; $display("FAIL timeout_none: rsp=%b err=%b rdata=%h sel=%b want 001 0 0badf00d 0",
                rsp_valid, rsp_err, rsp_rdata, m_apb_psel);
        end
`endif
        m_apb_pready = 1'b0;
        last = 0;
    endtask

    task automatic test_random();
        run_engine(600, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        for (int i = 0; i < N; i++) begin
            pw[i] = 0; pa[i] = '0; pd[i] = '0;
        end
        model_reset();
        test_reset();
        test_contention();
        test_single_read();
        test_write_read();
        test_error();
        test_reset_mid_access();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
